enytank_spawn_sched: RTL
========================

// Module: enytank_spawn_sched
// PURPOSE
//   Schedules (re)spawning of the enemy tank slots. It drives the per-slot tank_en
//   inputs of the enemy tank apps, replacing free-running generation with a paced,
//   round-robin, capacity-limited spawn sequence. Slot liveness comes back from the
//   tank apps' tank_state outputs. Runs in the clk_100M domain; game pacing arrives
//   as a one-cycle tick strobe.
// PARAMETERS
//   N_TANK      4   number of enemy tank slots (2..4)
//   SPAWN_GAP   8   ticks between the end of one spawn attempt and the next pick (0 = no gap)
//   MAX_ACTIVE  3   maximum live tanks; no pick while active_cnt >= MAX_ACTIVE
//   EN_HOLD     2   ticks tank_en is held waiting for the slot to report alive (>=1)
// PORTS
//   clk          in   1       system clock (clk_100M)
//   rst_n        in   1       asynchronous active-low reset
//   tick         in   1       one-cycle game-rate strobe (e.g. 4 Hz pulse)
//   game_en      in   1       1 = game running; 0 = scheduler idle
//   tank_state   in   N_TANK  per-slot alive flag (1 = alive)
//   tank_en      out  N_TANK  spawn request to the slot; at most one bit set
//   spawn_valid  out  1       1 while a spawn request is outstanding (ASSERT state)
//   spawn_slot   out  2       index of the slot being spawned / last spawned
//   active_cnt   out  3       registered popcount of tank_state
// BEHAVIOUR
// - Reset: state=IDLE; tank_en=0, spawn_valid=0, spawn_slot=0, active_cnt=0,
//   rr_ptr=0, gap_cnt=0, hold_cnt=0. Reset applies asynchronously mid-operation;
//   any pending request is dropped.
// - active_cnt: popcount(tank_state), registered each cycle (1-cycle latency).
// - FSM (all transitions on the clk rising edge):
//   IDLE:     outputs low. game_en=1 -> COOLDOWN, gap_cnt<=SPAWN_GAP.
//   COOLDOWN: on tick with gap_cnt>0, decrement. gap_cnt==0 -> PICK on the next cycle.
//             Ticks are not counted in any other state.
//   PICK:     evaluated every cycle. If active_cnt>=MAX_ACTIVE, or no slot has
//             tank_state=0, stay in PICK. Otherwise choose the first free slot at or
//             after rr_ptr, wrapping N_TANK-1 -> 0. Then: spawn_slot<=slot,
//             rr_ptr<=(slot+1) mod N_TANK, hold_cnt<=EN_HOLD, go to ASSERT.
//   ASSERT:   tank_en[spawn_slot]=1 and spawn_valid=1.
//             If tank_state[spawn_slot]=1 -> COOLDOWN, gap_cnt<=SPAWN_GAP.
//             Else, on tick: hold_cnt-1; at 0 -> COOLDOWN with gap reload (failed
//             spawn, rr_ptr stays advanced).
//             Alive and tick in the same cycle: alive wins.
// - tank_en is registered and one-hot or zero. It falls in the same cycle the FSM
//   leaves ASSERT.
// - game_en=0 in any state -> IDLE on the next edge; tank_en and spawn_valid clear
//   there. gap_cnt, hold_cnt and spawn_slot hold; rr_ptr is preserved.
// - A slot dying (tank_state 1->0) while another slot is being spawned has no effect
//   until the next PICK.
// - Counter widths: gap_cnt = $clog2(SPAWN_GAP+1), hold_cnt = $clog2(EN_HOLD+1)
//   (minimum 1 bit). Neither counter wraps below 0.
// TESTING
//   1. Reset, game_en=1, tank_state=0000, SPAWN_GAP=8: exactly 8 ticks, then PICK.
//      Next cycle tank_en=0001, spawn_slot=0. Force tank_state[0]=1: tank_en=0 the
//      following cycle.
//   2. Round-robin: four successful spawns with all slots free.
//      spawn_slot sequence = 0,1,2 then stall (MAX_ACTIVE=3, active_cnt=3).
//      Kill slot 1: next pick = slot 3 (rr_ptr=3), not slot 1.
//   3. Failed spawn: tank_state never rises, EN_HOLD=2. tank_en held for 2 ticks,
//      then clears. The following pick takes the next slot (wrap 3 -> 0 checked).
//   4. All slots alive, MAX_ACTIVE=4: FSM stays in PICK with tank_en=0.
//      Clear tank_state[2]: tank_en=0100 within 2 cycles.
//   5. game_en dropped mid-ASSERT: tank_en=0 next cycle. Re-enable:
//      SPAWN_GAP ticks elapse before the next request.
//   6. rst_n pulsed low mid-COOLDOWN and mid-ASSERT: all outputs 0 immediately,
//      without waiting for a clk edge. Restart pick begins at slot 0.

Source files
------------

// File: rtl/enytank_spawn_sched.sv
// Paced, round-robin, capacity-limited spawner for the enemy tank slots.
// Drives one tank_en bit at a time and waits for the slot to report alive.
`timescale 1ns/1ps
module enytank_spawn_sched #(
    parameter int N_TANK     = 4,
    parameter int SPAWN_GAP  = 8,
    parameter int MAX_ACTIVE = 3,
    parameter int EN_HOLD    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              game_en,
    input  logic [N_TANK-1:0] tank_state,
    output logic [N_TANK-1:0] tank_en,
    output logic              spawn_valid,
    output logic [1:0]        spawn_slot,
    output logic [2:0]        active_cnt
);

    localparam int GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
    localparam int HW = (EN_HOLD > 0) ? $clog2(EN_HOLD + 1) : 1;
    localparam logic [GW-1:0] GAP_INIT  = GW'(SPAWN_GAP);
    localparam logic [HW-1:0] HOLD_INIT = HW'(EN_HOLD);
    localparam logic [2:0]    MAX_A     = 3'(MAX_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COOLDOWN,
        S_PICK,
        S_ASSERT
    } state_t;

    state_t            state, state_n;
    logic [GW-1:0]     gap_cnt, gap_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic [1:0]        rr_ptr, rr_n;
    logic [1:0]        slot_n;
    logic [N_TANK-1:0] en_n;
    logic [2:0]        pop;
    logic              found;
    logic [1:0]        pick_slot;
    logic [1:0]        pick_next;
    logic [2*N_TANK-1:0] rot;
    logic              alive;

    function automatic logic [1:0] wrap_add(logic [1:0] a, int b);
        int s;
        s = int'(a) + b;
        if (s >= N_TANK) s = s - N_TANK;
        return 2'(s);
    endfunction

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_TANK; i++) pop = pop + 3'(tank_state[i]);
    end

    // Rotate so bit 0 is the slot at rr_ptr; lowest free bit wins.
    always_comb begin
        found     = 1'b0;
        pick_slot = '0;
        rot       = {tank_state, tank_state} >> rr_ptr;
        for (int k = N_TANK - 1; k >= 0; k--) begin
            if (!rot[k]) begin
                found     = 1'b1;
                pick_slot = wrap_add(rr_ptr, k);
            end
        end
        pick_next = wrap_add(pick_slot, 1);
    end

    assign alive = |(tank_state & tank_en);

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        hold_n  = hold_cnt;
        rr_n    = rr_ptr;
        slot_n  = spawn_slot;
        if (!game_en) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_COOLDOWN;
                    gap_n   = GAP_INIT;
                end
                S_COOLDOWN: begin
                    if (gap_cnt == '0) state_n = S_PICK;
                    else if (tick) gap_n = gap_cnt - GW'(1);
                end
                S_PICK: begin
                    if (active_cnt < MAX_A && found) begin
                        slot_n  = pick_slot;
                        rr_n    = pick_next;
                        hold_n  = HOLD_INIT;
                        state_n = S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (alive) begin
                        state_n = S_COOLDOWN;
                        gap_n   = GAP_INIT;
                    end else if (tick) begin
                        hold_n = (hold_cnt != '0) ? hold_cnt - HW'(1) : '0;
                        if (hold_n == '0) begin
                            state_n = S_COOLDOWN;
                            gap_n   = GAP_INIT;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // tank_en follows the next state so it drops on the edge leaving ASSERT.
    always_comb begin
        en_n = '0;
        for (int k = 0; k < N_TANK; k++)
            en_n[k] = (state_n == S_ASSERT) && (slot_n == 2'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            hold_cnt   <= '0;
            rr_ptr     <= '0;
            spawn_slot <= '0;
            tank_en    <= '0;
            active_cnt <= '0;
        end else begin
            state      <= state_n;
            gap_cnt    <= gap_n;
            hold_cnt   <= hold_n;
            rr_ptr     <= rr_n;
            spawn_slot <= slot_n;
            tank_en    <= en_n;
            active_cnt <= pop;
        end
    end

    assign spawn_valid = (state == S_ASSERT);

endmodule
